// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and constants used by the
// ALU decoder and the execute unit.
package alu_pkg;

    // Operation codes driven by the ALU decoder on ALUControl.
    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLT = 4'b0101,
        ALU_SLL = 4'b0110,
        ALU_SRL = 4'b0111,
        ALU_JAL = 4'b1000
    } alu_op_e;

    // Return-address offset added to the PC for JAL.
    localparam int unsigned ALU_JAL_OFFSET = 4;

    // Shifts take the iterative path; everything else finishes in one cycle.
    function automatic logic is_shift_op(input alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_logic.sv
// Single-cycle ALU operations (ADD..SLT, JAL) and illegal-code detection.
// Purely combinational; shifts are handled by the iterative shifter in the
// execute unit, so this block returns 0 for them.
module alu_logic
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    alu_op_e op;
    logic    lt_signed;

    assign op        = alu_op_e'(op_code);
    assign lt_signed = $signed(a) < $signed(b);

    // Select the single-cycle result; unknown codes yield 0 and flag Illegal.
    // NOTE: every output is given a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt_signed};
            ALU_JAL: result = a + WIDTH'(ALU_JAL_OFFSET);
            ALU_SLL,
            ALU_SRL: result = '0;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute unit. Single-cycle ops go straight to DONE; SLL/SRL
// walk a 1-bit-per-cycle shifter for k cycles before reaching DONE. Result,
// Zero and Illegal are registered and held until the consumer takes them.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Illegal
);

    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e            state;
    state_e            next_state;
    state_e            launch_state;

    alu_op_e           op_in;
    logic              accept;
    logic [SH_W-1:0]   sh_amt;
    logic              launch_shift;

    logic [WIDTH-1:0]  logic_result;
    logic              logic_illegal;
    logic [WIDTH-1:0]  launch_result;

    logic [WIDTH-1:0]  sh_reg;
    logic [WIDTH-1:0]  sh_next;
    logic [SH_W-1:0]   cnt;
    logic              shift_left;
    logic              last_shift;

    logic [WIDTH-1:0]  result_q;
    logic              zero_q;
    logic              illegal_q;

    // Request decode. in_ready looks at out_ready combinationally so a held
    // result can be retired and replaced on the same edge.
    assign op_in        = alu_op_e'(ALUControl);
    assign in_ready     = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept       = in_valid && in_ready;
    assign sh_amt       = SrcB[SH_W-1:0];
    assign launch_shift = is_shift_op(op_in) && (sh_amt != '0);
    assign launch_state = launch_shift ? SHIFT : DONE;

    // A zero-amount shift is simply A, so it completes like a single-cycle op.
    assign launch_result = is_shift_op(op_in) ? SrcA : logic_result;

    alu_logic #(
        .WIDTH (WIDTH)
    ) u_alu_logic (
        .op_code (ALUControl),
        .a       (SrcA),
        .b       (SrcB),
        .result  (logic_result),
        .illegal (logic_illegal)
    );

    // One step of the iterative shifter.
    assign sh_next    = shift_left ? (sh_reg << 1) : (sh_reg >> 1);
    assign last_shift = (cnt == SH_W'(1));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; an accept always wins since it can only happen in
    // IDLE or in DONE with out_ready high.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = launch_state;
            SHIFT:   if (last_shift) next_state = DONE;
            DONE: begin
                if (accept) begin
                    next_state = launch_state;
                end else if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shifter operand, step counter and direction, loaded on a shift accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_reg     <= '0;
            cnt        <= '0;
            shift_left <= 1'b0;
        end else if (accept && launch_shift) begin
            sh_reg     <= SrcA;
            cnt        <= sh_amt;
            shift_left <= (op_in == ALU_SLL);
        end else if (state == SHIFT) begin
            sh_reg <= sh_next;
            cnt    <= cnt - SH_W'(1);
        end
    end

    // Result registers: written when an op completes, otherwise held so the
    // outputs stay stable under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept && !launch_shift) begin
            result_q  <= launch_result;
            zero_q    <= (launch_result == '0);
            illegal_q <= logic_illegal;
        end else if ((state == SHIFT) && last_shift) begin
            result_q  <= sh_next;
            zero_q    <= (sh_next == '0);
            illegal_q <= 1'b0;
        end
    end

    assign out_valid = (state == DONE);
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign Illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver pushes hand-computed
// expectations (result, flags, cycle of first out_valid); a monitor pops
// and compares whenever the DUT presents a result.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Illegal;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          first_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   seen   = 0;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one op starting at a negedge; returns at the negedge after accept.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] res, input logic zero, input logic ill);
        exp_t e;
        int   waited;
        in_valid   = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        #1;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.res       = res;
        e.zero      = zero;
        e.ill       = ill;
        e.first_cyc = cyc + lat - 1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    endtask

    // Monitor: sample mid-low-phase, after the driver has settled its inputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                seen = 0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sb[0];
                    if (!seen) check("latency_cycle", cyc, e.first_cyc);
                    seen = 1;
                    check("result", ALUResult, e.res);
                    check("zero", 32'(Zero), 32'(e.zero));
                    check("illegal", 32'(Illegal), 32'(e.ill));
                    if (!out_ready) check("in_ready_held", 32'(in_ready), 32'd0);
                    else begin
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        ALUControl = 4'h0;
        SrcA       = '0;
        SrcB       = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", ALUResult, 32'd0);
        check("rst_zero", 32'(Zero), 32'd0);
        check("rst_illegal", 32'(Illegal), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Single-cycle ops.
        issue(4'b0001, 32'd5, 32'd5, 1, 32'h0, 1'b1, 1'b0);
        issue(4'b0001, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        issue(4'b0101, 32'hFFFF_FFFF, 32'd1, 1, 32'h1, 1'b0, 1'b0);
        issue(4'b0101, 32'd1, 32'hFFFF_FFFF, 1, 32'h0, 1'b1, 1'b0);
        issue(4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'h00F0_00F0, 1'b0, 1'b0);
        issue(4'b0011, 32'hF000_0000, 32'h0000_000F, 1, 32'hF000_000F, 1'b0, 1'b0);
        issue(4'b0100, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1, 32'h5555_5555, 1'b0, 1'b0);
        issue(4'b1000, 32'h0000_0100, 32'h0, 1, 32'h0000_0104, 1'b0, 1'b0);
        issue(4'b1001, 32'h1234_5678, 32'h1, 1, 32'h0, 1'b1, 1'b1);
        issue(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0, 1'b1, 1'b1);

        // Back-to-back ADDs with out_ready high.
        issue(4'b0000, 32'd3, 32'd4, 1, 32'd7, 1'b0, 1'b0);
        issue(4'b0000, 32'd10, 32'hFFFF_FFF6, 1, 32'd0, 1'b1, 1'b0);
        issue(4'b0000, 32'd7, 32'd8, 1, 32'd15, 1'b0, 1'b0);

        // Shifts: max amount, amount 0, amount 1, upper SrcB bits ignored.
        issue(4'b0110, 32'd1, 32'd31, 32, 32'h8000_0000, 1'b0, 1'b0);
        issue(4'b0111, 32'hDEAD_BEEF, 32'd0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        issue(4'b0111, 32'h8000_0000, 32'd4, 5, 32'h0800_0000, 1'b0, 1'b0);
        issue(4'b0110, 32'h8000_0001, 32'd1, 2, 32'h0000_0002, 1'b0, 1'b0);
        issue(4'b0111, 32'h0000_1234, 32'h0000_0020, 1, 32'h0000_1234, 1'b0, 1'b0);
        issue(4'b0111, 32'h0000_0001, 32'd1, 2, 32'h0, 1'b1, 1'b0);
        wait_drain();

        // Back-pressure: hold the result for 5 cycles, then retire and
        // accept the next op on the same edge.
        out_ready = 1'b0;
        issue(4'b0000, 32'h11, 32'h22, 1, 32'h33, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        issue(4'b0001, 32'h10, 32'h1, 1, 32'hF, 1'b0, 1'b0);
        wait_drain();

        // Reset in the middle of a shift: the op is dropped, no out_valid.
        issue(4'b0110, 32'h0000_00FF, 32'd10, 11, 32'h0003_FC00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", ALUResult, 32'd0);
        check("midrst_zero", 32'(Zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (15) @(negedge clk);

        // Unit still works after the aborted op.
        issue(4'b0000, 32'hFFFF_FFFF, 32'd2, 1, 32'd1, 1'b0, 1'b0);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute unit for the RV32I datapath. It consumes the 4-bit ALUControl code produced by the ALU decoder together with SrcA/SrcB operands and returns the result and Zero flag. Both sides use a valid/ready handshake. Logic and arithmetic ops complete in one cycle. SLL/SRL run on an iterative 1-bit-per-cycle shifter, so the block can replace the barrel shifter in area-constrained builds.

## Interface
Parameters:
- WIDTH, 32, operand/result width (power of two, ≥ 8)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  unit can accept a request this cycle
- ALUControl  in  4  operation code (encoding below)
- SrcA  in  WIDTH  operand A
- SrcB  in  WIDTH  operand B; bits [log2(WIDTH)-1:0] are the shift amount for shifts
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- ALUResult  out  WIDTH  registered result
- Zero  out  1  ALUResult == 0
- Illegal  out  1  code was not a defined encoding

## Operation
- Encodings: 0000 ADD A+B; 0001 SUB A−B; 0010 AND; 0011 OR; 0100 XOR; 0101 SLT (signed A<B → 1, else 0); 0110 SLL A<<B[sh]; 0111 SRL A>>B[sh] (logical); 1000 JAL A+4.
- Any other code: result 0, Illegal=1, latency 1.
- Arithmetic is modulo 2^WIDTH. The carry out is discarded.
- Accept condition: in_valid && in_ready at a rising edge. Operands and code are captured at that edge; inputs are ignored afterwards.
- FSM states:
  - IDLE → DONE on accept of a non-shift op or a shift with amount 0.
  - IDLE → SHIFT on accept of a shift with amount k>0. Load the shift register with A and the counter with k.
  - SHIFT: shift by 1 each cycle and decrement the counter. At counter==1 the state goes to DONE on the same edge as the final shift.
  - DONE → IDLE on out_ready with no new accept.
  - DONE → DONE/SHIFT on out_ready with a simultaneous accept (back-to-back).
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from out_ready, which is permitted.
- out_valid = (state==DONE). ALUResult, Zero and Illegal are stable while out_valid && !out_ready.
- Zero and Illegal are registered alongside ALUResult. They are not derived combinationally from the output.

## Timing
- Reset (async assert, sync-release expected upstream):
  - state=IDLE; ALUResult=0, Zero=0, Illegal=0, out_valid=0.
  - in_ready=1 in the first cycle after release.
- Latency, counted from the accept edge N to out_valid high:
  - 1 cycle for non-shift ops and for shift amount 0.
  - k+1 cycles for a shift by k; the maximum is WIDTH for amount WIDTH−1.
- Throughput: 1 op/cycle for single-cycle ops when out_ready is held high.
- Reset asserted mid-SHIFT or in DONE discards the in-flight op. No out_valid pulse follows.
- Back-pressure: a result is held indefinitely in DONE. No new op is accepted until out_ready.

## Structure
- Shared package alu_pkg:
  - typedef enum logic [3:0] alu_op_e {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_JAL} with the encodings above.
  - Constant ALU_JAL_OFFSET = 4.
  - The decoder is updated to drive alu_op_e.
- FSM state enum {IDLE, SHIFT, DONE} is local to the module.
- Sub-module alu_logic: purely combinational single-cycle ops (ADD…SLT, JAL, Illegal detect). The shifter, counter and FSM stay in alu_exec_unit.

## Test plan
- Reset: hold rst_n=0 mid-stream → all outputs 0, in_ready=1 after release, no spurious out_valid.
- SUB with A=5, B=5 → ALUResult=0, Zero=1 one cycle after accept. SLT with A=0xFFFFFFFF, B=1 → 1.
- SLL with A=1, B=31 → out_valid exactly 32 cycles after accept, result 0x80000000. SRL with B=0 → result=A after 1 cycle.
- Back-to-back ADDs with out_ready=1: 3+4, 10+0xFFFFFFF6, 7+8 → results 7, 0 (Zero=1), 15 on consecutive cycles.
- Back-pressure: out_ready=0 for 5 cycles during DONE → result stable and in_ready=0; accept the next op on the cycle out_ready rises.
- Code 1001 → Illegal=1, result 0. JAL with A=0x100 → 0x104, Illegal=0.
